// File: rtl/arbitrated_fifo_bank.sv
// Bank of NUM_FIFOS circular FIFOs behind one push port, drained by a fair
// round-robin arbiter onto a tagged valid/ready output. Optional: OVERFLOW_STICKY_EN.
module arbitrated_fifo_bank #(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [TAGWIDTH-1:0]  push_sel,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 push_rdy,
  input  logic [NUM_FIFOS-1:0] reqs,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_out_vld,
  output logic [TAGWIDTH-1:0]  data_out_tag,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [NUM_FIFOS-1:0] full,
  output logic [NUM_FIFOS-1:0] empty,
  output logic [NUM_FIFOS-1:0] ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wptr_q [NUM_FIFOS];
  logic [PW-1:0]        wptr_d [NUM_FIFOS];
  logic [PW-1:0]        rptr_q [NUM_FIFOS];
  logic [PW-1:0]        rptr_d [NUM_FIFOS];
  logic [WIDTH-1:0]     mem_q  [NUM_FIFOS][DEPTH];
  logic [WIDTH-1:0]     head   [NUM_FIFOS];
  logic [TAGWIDTH-1:0]  ptr_q, ptr_d;
  logic [NUM_FIFOS-1:0] elig, sel_hit, push_acc, pop;
  logic                 xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
      // Extra wrap bit distinguishes full from empty when the indices match.
      assign empty[gi]    = (wptr_q[gi] == rptr_q[gi]);
      assign full[gi]     = (wptr_q[gi][AW] != rptr_q[gi][AW]) &&
                            (wptr_q[gi][AW-1:0] == rptr_q[gi][AW-1:0]);
      assign head[gi]     = mem_q[gi][rptr_q[gi][AW-1:0]];
      assign sel_hit[gi]  = (push_sel == TAGWIDTH'(gi));
      assign push_acc[gi] = push & sel_hit[gi] & ~full[gi];
      assign pop[gi]      = gnt[gi] & out_rdy;
      assign elig[gi]     = reqs[gi] & ~empty[gi];
      assign wptr_d[gi]   = wptr_q[gi] + PW'(push_acc[gi]);
      assign rptr_d[gi]   = rptr_q[gi] + PW'(pop[gi]);
    end
  endgenerate

  // An out-of-range push_sel hits no FIFO, so it is never ready.
  assign push_rdy = |(sel_hit & ~full);

  always_comb begin
    int idx_i;
    logic [TAGWIDTH-1:0] idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx_i = 0;
    idx   = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      idx_i = int'(ptr_q) + k;
      if (idx_i >= NUM_FIFOS) idx_i = idx_i - NUM_FIFOS;
      idx = TAGWIDTH'(idx_i);
      if (!found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    data_out     = '0;
    data_out_tag = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (gnt[i]) begin
        data_out     = data_out | head[i];
        data_out_tag = data_out_tag | TAGWIDTH'(i);
      end
    end
  end

  assign data_out_vld = |gnt;
  assign xfer         = data_out_vld & out_rdy;

  // Pointer only advances on a real transfer, so a stalled grant stays put.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (int'(data_out_tag) == NUM_FIFOS - 1) ptr_d = '0;
      else                                     ptr_d = data_out_tag + TAGWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (push_acc[i]) mem_q[i][wptr_q[i][AW-1:0]] <= data_in;
    end
  end

`ifdef OVERFLOW_STICKY_EN
  logic [NUM_FIFOS-1:0] ovf_q, ovf_d;

  assign ovf_d = ovf_q | ({NUM_FIFOS{push}} & sel_hit & full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

endmodule

// File: doc/arbitrated_fifo_bank.md
# arbitrated_fifo_bank

Bank of NUM_FIFOS independent circular FIFOs behind a single push port, drained through a registered round-robin arbiter onto one tagged valid/ready output. It replaces the abstract, assumption-driven arbiter used in the arbitrated-FIFO proof tops with a concrete, fair arbiter. It sits between a multi-source producer and a single downstream consumer. It is the DUT that scoreboard-based formal tops bind to, with the tracked FIFO selected by tag.

## Interface
- NUM_FIFOS, 4, number of FIFOs/channels (≥2)
- WIDTH, 8, data word width
- DEPTH, 8, entries per FIFO (power of two, ≥2)
- TAGWIDTH, $clog2(NUM_FIFOS), channel tag width
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- push  input  1  write request
- push_sel  input  TAGWIDTH  target FIFO for push
- data_in  input  WIDTH  write data
- push_rdy  output  1  target FIFO not full; push accepted iff push && push_rdy
- reqs  input  NUM_FIFOS  per-channel request enable
- out_rdy  input  1  downstream ready
- data_out  output  WIDTH  head word of granted FIFO, 0 when none
- data_out_vld  output  1  a grant is active
- data_out_tag  output  TAGWIDTH  index of granted FIFO, 0 when none
- gnt  output  NUM_FIFOS  one-hot grant, 0 when none
- full, empty  output  NUM_FIFOS  per-FIFO status
- ovf  output  NUM_FIFOS  sticky overflow flags (see Configuration)

## Operation
- Eligibility: elig[i] = reqs[i] & ~empty[i].
- Arbiter: rotating priority starting at pointer ptr (TAGWIDTH bits).
  - gnt selects the first eligible index at or after ptr, modulo NUM_FIFOS.
  - gnt is combinational from elig and ptr. It is one-hot, or zero iff elig == 0.
- Pop: pop[i] = gnt[i] & out_rdy. Exactly one FIFO pops per transfer.
- ptr update: on a transfer (data_out_vld && out_rdy), ptr <= granted index + 1, wrapping at NUM_FIFOS−1 → 0. Otherwise ptr holds.
  - A stalled grant therefore stays on the same FIFO; it does not rotate away.
  - Non-power-of-two NUM_FIFOS: ptr is never loaded with a value ≥ NUM_FIFOS.
- FIFOs: each holds read/write pointers of $clog2(DEPTH)+1 bits, with the wrap bit used for full/empty.
  - full: pointers differ only in the wrap bit. empty: pointers are equal.
- Push:
  - Accepted writes go to FIFO push_sel only.
  - A push to a full FIFO is dropped, and that FIFO's contents are unchanged.
  - push_sel ≥ NUM_FIFOS: push_rdy=0 and the push is dropped.
- Simultaneous push and pop on the same FIFO:
  - Non-full: both happen; occupancy is unchanged.
  - Full: the push is still rejected. push_rdy depends on full only, never on out_rdy.
- data_out is the one-hot mux of FIFO heads by gnt. data_out_tag is the binary encoding of gnt.

## Timing
- Reset (async assert, deasserted synchronously by the environment):
  - all FIFOs empty; ptr=0; ovf=0.
  - gnt=0, data_out_vld=0, data_out=0, data_out_tag=0.
  - full=0, empty=all-ones, push_rdy=1.
- Write-to-output latency is 1 cycle. A word pushed in cycle N is eligible in cycle N+1. There is no same-cycle bypass into an empty FIFO.
- Output is valid/ready. While data_out_vld && !out_rdy and reqs is unchanged, data_out, data_out_tag and gnt are held stable.
- If reqs deasserts for the granted channel, the grant may move or drop in the same cycle. The consumer sees this as a combinational change.
- Reset mid-operation flushes all contents immediately. No partial transfer completes.

## Configuration
- OVERFLOW_STICKY_EN defined:
  - ovf[i] sets on the cycle a push to FIFO i is dropped because FIFO i is full.
  - ovf[i] clears only on rst.
- Not defined: ovf is tied to 0, and dropped pushes are silent. All other behaviour is identical.

## Test plan
- Reset, then push 0xA1 to FIFO 2 with reqs=all-ones and out_rdy=1.
  - Next cycle: data_out_vld=1, data_out=0xA1, data_out_tag=2, gnt=4'b0100.
  - Following cycle: FIFO 2 is empty and data_out_vld=0.
- Fill FIFOs 0–3 with 2 words each, reqs=all-ones, out_rdy=1.
  - Tags observed: 0,1,2,3,0,1,2,3 (8 transfers over 8 consecutive cycles).
  - ptr returns to 0.
- Stall: FIFO 1 and FIFO 3 are non-empty, out_rdy=0 for 5 cycles.
  - tag=1 and data are held for all 5 cycles.
  - When out_rdy=1, the word from FIFO 1 transfers, then tag=3.
- Overflow: push DEPTH+1 words to FIFO 0 with reqs=0.
  - push_rdy=0 on the last push, and the FIFO holds the first DEPTH words.
  - With OVERFLOW_STICKY_EN defined: ovf[0]=1 and stays set.
  - Without it: ovf=0.
- FIFO 0 full, push to FIFO 0 and pop FIFO 0 in the same cycle.
  - The push is rejected and occupancy drops to DEPTH−1.
  - A repeat push on the next cycle is accepted.
- Assert rst while 3 FIFOs are non-empty and a grant is active.
  - The same cycle (asynchronously): data_out_vld=0, empty=all-ones, ptr=0.
